rr_mux_arbiter: RTL

Round-robin arbiter that shares one 4:1 datapath mux, and the resource behind it, between four requesters (e.g. fetch, load/store, debug, DMA).
- Registers a one-hot grant and the matching 2-bit select that drives the mux select input directly.
- Holds ownership until the resource signals completion, then rotates priority.
- Sits between the requesters and the shared bus/mux in the core's memory-access path.

---
 rtl/rr_mux_arbiter_if.sv | 35 +++
 rtl/rr_mux_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_if.sv
//------------------------------------------------------------------------------
// rr_mux_arbiter_if: request/grant bundle between four requesters and the arbiter.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rr_mux_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  // master: the arbiter itself; slave: requesters plus the shared resource
  modport master (
    input  req,
    input  done,
    output gnt,
    output sel,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  busy,
    input  timeout
  );
endinterface

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
//------------------------------------------------------------------------------
// rr_mux_arbiter: 4-way round-robin arbiter driving a shared 4:1 mux select.
// Rev 1.0 -- define ARB_TIMEOUT_EN to enable forced release after MAX_HOLD cycles.
//------------------------------------------------------------------------------
`default_nettype none

module rr_mux_arbiter #(
  parameter int         MAX_HOLD = 16,
  parameter logic [1:0] PARK_SEL = 2'd0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  rr_mux_arbiter_if.master  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_mux_arbiter: MAX_HOLD must be >= 2");
  end

  state_t     state_q, state_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] ptr_q,   ptr_d;
  logic       busy_q,  busy_d;

  logic       w_force;
  logic [2:0] w_pick_idle;
  logic [2:0] w_pick_hand;

  // Returns {found, index}; scanning from lowest to highest priority lets the
  // highest-priority hit overwrite the others without an early exit.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign w_pick_idle = rr_pick(bus.req, ptr_q);
  // On handoff the outgoing owner becomes the new pointer, so it searches last.
  assign w_pick_hand = rr_pick(bus.req, sel_q);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q;

  assign w_force = (state_q == S_OWN) && !bus.done &&
                   (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Counter runs only while a grant is held without done; any release clears it.
  always_comb begin
    hold_d = '0;
    if ((state_q == S_OWN) && !bus.done && !w_force) hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= w_force;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign w_force     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (w_pick_idle[2]) begin
          state_d = S_OWN;
          gnt_d   = 4'b0001 << w_pick_idle[1:0];
          sel_d   = w_pick_idle[1:0];
          busy_d  = 1'b1;
        end
      end
      S_OWN: begin
        if (bus.done || w_force) begin
          ptr_d = sel_q;
          if (w_pick_hand[2]) begin
            gnt_d = 4'b0001 << w_pick_hand[1:0];
            sel_d = w_pick_hand[1:0];
          end else begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= PARK_SEL;
      ptr_q   <= 2'd3;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

`default_nettype wire
